hamming_framer: RTL and testbench

Upstream stage of the VAD power-spectrum path. Accepts a stream of 16-bit signed PCM samples, stores them in an overlap buffer, and forms frames of FRAME_LEN samples every HOP samples. Each frame is multiplied by a Hamming window and converted to IEEE-754 single precision. Frames are emitted as one contiguous valid burst on `hamm_stream`, which feeds `power_spectrum`.

---
 rtl/hamming_framer.sv | 182 ++++++++++++++++++
 tb/tb_hamming_framer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hamming_framer.sv
// Overlap buffer + Hamming window + float conversion for the VAD spectrum path.
// Define HAMM_PREEMPH_EN to apply a 0.97 pre-emphasis filter on the write path.
module hamming_framer #(
  parameter int FRAME_LEN = 512,
  parameter int HOP       = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tvalid_pcm,
  input  logic [15:0] pcm,
  output logic        tvalid_hamm_stream,
  output logic [31:0] hamm_stream,
  output logic        frame_last,
  output logic        overrun
);

  localparam int AW   = $clog2(2 * FRAME_LEN);
  localparam int IW   = $clog2(FRAME_LEN);
  localparam int HALF = FRAME_LEN / 2;
  localparam int WAW  = $clog2(HALF);

  // Window coefficient in Q28 fixed point; cosine via Taylor series on [0, pi/2].
  function automatic logic [15:0] win_coef(input int n);
    longint s, pi_q, d, m, x, x2, term, c;
    logic   neg;
    s    = 64'sd268435456;
    pi_q = 64'sd843314857;
    d    = longint'(FRAME_LEN - 1);
    m    = longint'(2 * n);
    neg  = (2 * m > d);
    if (neg) m = d - m;
    x    = pi_q * m / d;
    x2   = x * x / s;
    term = s;
    c    = s;
    for (int k = 1; k <= 12; k++) begin
      term = -(term * x2 / s) / longint'((2 * k - 1) * (2 * k));
      c    = c + term;
    end
    if (neg) c = -c;
    return 16'((64'sd32768 * (64'sd54 * s - 64'sd46 * c) + 64'sd50 * s) / (64'sd100 * s));
  endfunction

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  state_t             state, state_next;
  logic [IW-1:0]      cnt, rd_idx;
  logic [AW-1:0]      wr_ptr, start, rd_addr;
  logic [WAW-1:0]     win_idx;
  logic [15:0]        wr_data, s1_w;
  logic [15:0]        ram [2 * FRAME_LEN];
  logic [15:0]        win_rom [HALF];
  logic signed [15:0] s1_sample;
  logic signed [16:0] w_ext;
  logic signed [31:0] s2_prod;
  logic               due, accept, s1_valid, s1_last, s2_valid, s2_last;
  logic               conv_sign;
  logic [31:0]        conv_mag, conv_norm, conv_float;
  logic [4:0]         conv_lead;

  for (genvar gi = 0; gi < HALF; gi++) begin : g_win
    localparam logic [15:0] COEF = win_coef(gi);
    assign win_rom[gi] = COEF;
  end

`ifdef HAMM_PREEMPH_EN
  logic signed [15:0] x_prev;
  logic signed [31:0] pe_prod;
  logic signed [16:0] pe_diff;

  // Pre-emphasis y = x - (0.97*x_prev), saturated to 16 bits.
  always_comb begin
    pe_prod = x_prev * 32'sd31785;
    pe_diff = {pcm[15], pcm} - pe_prod[31:15];
    if (pe_diff[16] != pe_diff[15]) begin
      wr_data = pe_diff[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      wr_data = pe_diff[15:0];
    end
  end

  // Previous raw sample for the filter; zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev <= 16'sd0;
    end else if (tvalid_pcm) begin
      x_prev <= pcm;
    end
  end
`else
  assign wr_data = pcm;
`endif

  assign due     = tvalid_pcm && (cnt == IW'(FRAME_LEN - 1));
  assign accept  = due && (state == IDLE);
  assign rd_addr = start + AW'(rd_idx);
  // Second half of the frame mirrors the first: FRAME_LEN-1-n is ~n in the low bits.
  assign win_idx = rd_idx[IW-1] ? ~rd_idx[WAW-1:0] : rd_idx[WAW-1:0];
  assign w_ext   = signed'({1'b0, s1_w});

  // Next-state logic for the emission sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? EMIT : IDLE;
      EMIT:    state_next = (rd_idx == IW'(FRAME_LEN - 1)) ? GAP : EMIT;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, sample counting, read pointer and pipeline valid tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_idx   <= '0;
      start    <= '0;
      overrun  <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      state <= state_next;
      if (tvalid_pcm) begin
        wr_ptr <= wr_ptr + AW'(1);
        cnt    <= due ? IW'(FRAME_LEN - HOP) : cnt + IW'(1);
      end
      if (accept) begin
        start  <= wr_ptr + AW'(1) - AW'(FRAME_LEN);
        rd_idx <= '0;
      end else if (state == EMIT) begin
        rd_idx <= rd_idx + IW'(1);
      end
      if (due && state != IDLE) overrun <= 1'b1;
      s1_valid <= (state == EMIT);
      s1_last  <= (state == EMIT) && (rd_idx == IW'(FRAME_LEN - 1));
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  // Buffer write, registered RAM/ROM read, and the window multiply.
  always_ff @(posedge clk) begin
    if (tvalid_pcm) ram[wr_ptr] <= wr_data;
    s1_sample <= ram[rd_addr];
    s1_w      <= win_rom[win_idx];
    s2_prod   <= 32'(s1_sample) * 32'(w_ext);
  end

  // Q2.30 product to IEEE-754 single, truncating below the mantissa.
  always_comb begin
    conv_sign = s2_prod[31];
    conv_mag  = conv_sign ? 32'(-s2_prod) : s2_prod;
    conv_lead = 5'd0;
    for (int i = 0; i < 31; i++) begin
      conv_lead = conv_mag[i] ? 5'(i) : conv_lead;
    end
    conv_norm = conv_mag << (5'd31 - conv_lead);
    if (conv_mag == 32'd0) begin
      conv_float = 32'd0;
    end else begin
      conv_float = {conv_sign, 8'd97 + {3'd0, conv_lead}, 23'(conv_norm >> 8)};
    end
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_hamm_stream <= 1'b0;
      hamm_stream        <= 32'd0;
      frame_last         <= 1'b0;
    end else begin
      tvalid_hamm_stream <= s2_valid;
      hamm_stream        <= s2_valid ? conv_float : 32'd0;
      frame_last         <= s2_valid && s2_last;
    end
  end

endmodule

// File: tb/tb_hamming_framer.sv
// Directed self-checking bench for hamming_framer (FRAME_LEN=512, HOP=256).
module tb_hamming_framer;

`ifdef HAMM_PREEMPH_EN
  localparam logic [31:0] EXP_C255    = 32'h3C760000;
  localparam logic [31:0] EXP_C511    = 32'h3A9D69E0;
  localparam logic [31:0] EXP_STEP256 = 32'h3C760000;
`else
  localparam logic [31:0] EXP_C255    = 32'h3F000000;
  localparam logic [31:0] EXP_C511    = 32'h3D23D000;
  localparam logic [31:0] EXP_STEP256 = 32'h3F000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid_pcm = 1'b0;
  logic [15:0] pcm = 16'd0;
  logic        tvalid_hamm_stream, frame_last, overrun;
  logic [31:0] hamm_stream;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [31:0] cap [4][512];
  int burst_len [4];
  int first_cyc [4];
  int last_pos [4];
  int nbursts, last_cnt, min_gap, gap_run, nz_idle, b;
  bit in_burst;

  hamming_framer dut (
    .clk(clk), .rst(rst), .tvalid_pcm(tvalid_pcm), .pcm(pcm),
    .tvalid_hamm_stream(tvalid_hamm_stream), .hamm_stream(hamm_stream),
    .frame_last(frame_last), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Burst recorder: clears while rst is high.
  always @(negedge clk) begin
    if (rst) begin
      nbursts = 0; last_cnt = 0; min_gap = 1000000; gap_run = 0; nz_idle = 0; in_burst = 0;
      for (int i = 0; i < 4; i++) begin burst_len[i] = 0; first_cyc[i] = -1; last_pos[i] = -1; end
    end else if (tvalid_hamm_stream) begin
      if (!in_burst) begin
        if (nbursts > 0 && gap_run < min_gap) min_gap = gap_run;
        if (nbursts < 4) begin first_cyc[nbursts] = cyc; burst_len[nbursts] = 0; end
        nbursts++;
      end
      in_burst = 1; gap_run = 0;
      if (nbursts <= 4) begin
        b = nbursts - 1;
        if (burst_len[b] < 512) cap[b][burst_len[b]] = hamm_stream;
        if (frame_last) last_pos[b] = burst_len[b];
        burst_len[b]++;
      end
      if (frame_last) last_cnt++;
    end else begin
      in_burst = 0; gap_run++;
      if (hamm_stream !== 32'd0 || frame_last !== 1'b0) nz_idle++;
    end
  end

  task automatic send(input logic [15:0] v, input int sp);
    tvalid_pcm = 1'b1; pcm = v;
    @(negedge clk);
    tvalid_pcm = 1'b0;
    last_acc = cyc;
    repeat (sp - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tvalid_pcm = 1'b0; pcm = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tvalid_hamm_stream !== 1'b0 || hamm_stream !== 32'd0 || frame_last !== 1'b0 || overrun !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL reset_idle got=%0d bad cycles exp=0", bad); end
    checks++; if (hamm_stream !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", hamm_stream); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (nbursts !== 0) begin failures++; $display("FAIL reset_bursts got=%0d exp=0", nbursts); end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 512; i++) send(16'h4000, 4);
    repeat (600) @(negedge clk);
    checks++; if (nbursts !== 1) begin failures++; $display("FAIL const_bursts got=%0d exp=1", nbursts); end
    checks++; if (burst_len[0] !== 512) begin failures++; $display("FAIL const_len got=%0d exp=512", burst_len[0]); end
    checks++; if (first_cyc[0] !== last_acc + 3) begin failures++; $display("FAIL const_latency got=%0d exp=%0d", first_cyc[0], last_acc + 3); end
    checks++; if (cap[0][0] !== 32'h3D23D000) begin failures++; $display("FAIL const_s0 got=%h exp=3d23d000", cap[0][0]); end
    checks++; if (cap[0][255] !== EXP_C255) begin failures++; $display("FAIL const_s255 got=%h exp=%h", cap[0][255], EXP_C255); end
    checks++; if (cap[0][256] !== EXP_C255) begin failures++; $display("FAIL const_s256 got=%h exp=%h", cap[0][256], EXP_C255); end
    checks++; if (cap[0][511] !== EXP_C511) begin failures++; $display("FAIL const_s511 got=%h exp=%h", cap[0][511], EXP_C511); end
    checks++; if (last_cnt !== 1) begin failures++; $display("FAIL const_last_cnt got=%0d exp=1", last_cnt); end
    checks++; if (last_pos[0] !== 511) begin failures++; $display("FAIL const_last_pos got=%0d exp=511", last_pos[0]); end
    checks++; if (nz_idle !== 0) begin failures++; $display("FAIL const_idle_data got=%0d exp=0", nz_idle); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL const_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_sign_zero();
    do_reset();
    for (int i = 0; i < 512; i++) send((i == 255) ? 16'h8000 : 16'h0000, 2);
    repeat (600) @(negedge clk);
    checks++; if (nbursts !== 1) begin failures++; $display("FAIL sign_bursts got=%0d exp=1", nbursts); end
    checks++; if (cap[0][255] !== 32'hBF800000) begin failures++; $display("FAIL sign_neg got=%h exp=bf800000", cap[0][255]); end
    checks++; if (cap[0][254] !== 32'h00000000) begin failures++; $display("FAIL sign_zero254 got=%h exp=0", cap[0][254]); end
    checks++; if (cap[0][0] !== 32'h00000000) begin failures++; $display("FAIL sign_zero0 got=%h exp=0", cap[0][0]); end
  endtask

  task automatic test_hop();
    do_reset();
    for (int i = 0; i < 768; i++) send(16'(i), 4);
    repeat (600) @(negedge clk);
    checks++; if (nbursts !== 2) begin failures++; $display("FAIL hop_bursts got=%0d exp=2", nbursts); end
    checks++; if (burst_len[1] !== 512) begin failures++; $display("FAIL hop_len got=%0d exp=512", burst_len[1]); end
    checks++; if (min_gap < 1) begin failures++; $display("FAIL hop_gap got=%0d exp>=1", min_gap); end
    checks++; if (last_cnt !== 2) begin failures++; $display("FAIL hop_last_cnt got=%0d exp=2", last_cnt); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL hop_overrun got=%b exp=0", overrun); end
    checks++; if (cap[0][0] !== 32'h00000000) begin failures++; $display("FAIL hop_f0s0 got=%h exp=0", cap[0][0]); end
`ifndef HAMM_PREEMPH_EN
    checks++; if (cap[0][255] !== 32'h3BFF0000) begin failures++; $display("FAIL hop_f0s255 got=%h exp=3bff0000", cap[0][255]); end
    checks++; if (cap[1][0] !== 32'h3A23D000) begin failures++; $display("FAIL hop_f1s0 got=%h exp=3a23d000", cap[1][0]); end
    checks++; if (cap[1][255] !== 32'h3C7F8000) begin failures++; $display("FAIL hop_f1s255 got=%h exp=3c7f8000", cap[1][255]); end
`endif
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 800; i++) send(16'h4000, 1);
    repeat (600) @(negedge clk);
    checks++; if (nbursts !== 1) begin failures++; $display("FAIL ovr_bursts got=%0d exp=1", nbursts); end
    checks++; if (burst_len[0] !== 512) begin failures++; $display("FAIL ovr_len got=%0d exp=512", burst_len[0]); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    checks++; if (cap[0][255] !== EXP_C255) begin failures++; $display("FAIL ovr_s255 got=%h exp=%h", cap[0][255], EXP_C255); end
    repeat (50) @(negedge clk);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid();
    int vcount;
    do_reset();
    for (int i = 0; i < 512; i++) send(16'h4000, 4);
    vcount = 0;
    for (int k = 0; k < 3000 && vcount < 100; k++) begin
      if (tvalid_hamm_stream === 1'b1) vcount++;
      if (vcount < 100) @(negedge clk);
    end
    checks++; if (vcount !== 100) begin failures++; $display("FAIL mid_burst_seen got=%0d exp=100", vcount); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tvalid_hamm_stream !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", tvalid_hamm_stream); end
    checks++; if (hamm_stream !== 32'd0) begin failures++; $display("FAIL mid_data got=%h exp=0", hamm_stream); end
    checks++; if (frame_last !== 1'b0) begin failures++; $display("FAIL mid_last got=%b exp=0", frame_last); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 511; i++) send((i < 255) ? 16'h0000 : 16'h4000, 2);
    repeat (600) @(negedge clk);
    checks++; if (nbursts !== 0) begin failures++; $display("FAIL mid_511 got=%0d bursts exp=0", nbursts); end
    send(16'h4000, 2);
    repeat (600) @(negedge clk);
    checks++; if (nbursts !== 1) begin failures++; $display("FAIL mid_512 got=%0d bursts exp=1", nbursts); end
    checks++; if (burst_len[0] !== 512) begin failures++; $display("FAIL mid_len got=%0d exp=512", burst_len[0]); end
    checks++; if (cap[0][0] !== 32'h00000000) begin failures++; $display("FAIL mid_s0 got=%h exp=0", cap[0][0]); end
    checks++; if (cap[0][255] !== 32'h3F000000) begin failures++; $display("FAIL mid_step got=%h exp=3f000000", cap[0][255]); end
    checks++; if (cap[0][256] !== EXP_STEP256) begin failures++; $display("FAIL mid_step1 got=%h exp=%h", cap[0][256], EXP_STEP256); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_constant();
    test_sign_zero();
    test_hop();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
